// File: rtl/dmem_access_unit.sv
// Data-memory access unit.
// This block takes the memory stage's combinational access request and turns it
// into a valid / addr_ok / data_ok transaction on the data bus. It stalls the
// pipeline until the transaction completes, then holds the raw read word until
// the stage advances, so the same access is never issued twice.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access outstanding; a pending request stalls immediately
// ADDR  | dreq_valid high, waiting for addr_ok (data_ok may arrive too)
// DATA  | address accepted, waiting for data_ok
// HOLD  | result held in rdata with done=1 until pipe_advance or flush
module dmem_access_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_strobe,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  input  logic        pipe_advance,
  input  logic        flush,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_HOLD
  } state_t;

  // Counter value at which the next cycle in ADDR/DATA would reach TIMEOUT.
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             abort_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load_req;
  logic             capture;
  logic             set_err;
  logic             timeout_hit;
  logic             in_bus;

  assign in_bus      = (state_q == S_ADDR) || (state_q == S_DATA);
  // >= rather than == so that an addr_ok taken on the last allowed ADDR cycle
  // still times out in DATA once the counter has saturated.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= TO_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs; a completing handshake wins over timeout.
  always_comb begin
    state_d    = state_q;
    dreq_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    load_req   = 1'b0;
    capture    = 1'b0;
    set_err    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          busy     = 1'b1;
          load_req = 1'b1;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        dreq_valid = 1'b1;
        busy       = 1'b1;
        if (dresp_addr_ok && dresp_data_ok) begin
          if (abort_q || flush) begin
            state_d = S_IDLE;
          end else begin
            capture = 1'b1;
            state_d = S_HOLD;
          end
        end else if (dresp_addr_ok) begin
          state_d = S_DATA;
        end else if (timeout_hit) begin
          set_err = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        if (dresp_data_ok) begin
          if (abort_q || flush) begin
            state_d = S_IDLE;
          end else begin
            capture = 1'b1;
            state_d = S_HOLD;
          end
        end else if (timeout_hit) begin
          set_err = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        done = 1'b1;
        if (pipe_advance || flush) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus request latch, read capture, abort flag, timeout counter and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dreq_addr   <= '0;
      dreq_size   <= '0;
      dreq_strobe <= '0;
      dreq_data   <= '0;
      rdata       <= '0;
      abort_q     <= 1'b0;
      cnt_q       <= '0;
      bus_err     <= 1'b0;
    end else begin
      if (load_req) begin
        dreq_addr   <= req_addr;
        dreq_size   <= req_size;
        dreq_strobe <= req_strobe;
        dreq_data   <= req_wdata;
      end
      if (capture) rdata <= dresp_data;
      if (load_req)              abort_q <= 1'b0;
      else if (in_bus && flush)  abort_q <= 1'b1;
      if (load_req)                  cnt_q <= '0;
      else if (in_bus && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      if (set_err) bus_err <= 1'b1;
    end
  end

endmodule
